// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA job arbiter slice.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OP_DECRYPT = 1'b0;
  localparam logic OP_ENCRYPT = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr wins.
module rr_arbiter
  import rsa_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  // Walk from the lowest priority offset up, so the closest request to ptr is the last writer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ((int'(ptr) + k) % NREQ) == i) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one RSA mod-exp engine between NREQ requesters and tags results with the requester ID.
// Build option: define RSA_ARB_WDOG_EN to abort jobs whose engine stays silent for TIMEOUT cycles.
module rsa_job_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH   = RSA_WIDTH,
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_op,
  input  logic [NREQ*WIDTH-1:0]  req_msg,
  output logic                   eng_start,
  output logic                   eng_op,
  output logic [WIDTH-1:0]       eng_msg,
  input  logic                   eng_done,
  input  logic [WIDTH-1:0]       eng_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   busy
);

  // state | meaning
  // IDLE  | no job in flight; arbitrate and accept one request
  // ISSUE | one-cycle start pulse to the engine
  // WAIT  | engine running; wait for eng_done (or watchdog expiry)
  // RESP  | result presented until rsp_ready

  arb_state_t      state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  job_id;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            sel_op;
  logic [WIDTH-1:0] sel_msg;
  logic            accept;
  logic            done_hit;
  logic            timeout_hit;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept   = (state == IDLE) && (|req_valid);
  assign done_hit = (state == WAIT) && eng_done;

  always_comb begin
    sel_op  = OP_DECRYPT;
    sel_msg = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = req_op[i];
        sel_msg = req_msg[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef RSA_ARB_WDOG_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);

  logic [CNTW-1:0] wdog_cnt;
  logic            err_q;

  // Zero whenever not in WAIT, so every wait starts from a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               wdog_cnt <= '0;
    else if (state != WAIT)  wdog_cnt <= '0;
    else                     wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign timeout_hit = (state == WAIT) && !eng_done && (wdog_cnt == CNTW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            err_q <= 1'b0;
    else if (done_hit)    err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end

  assign rsp_err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (eng_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    eng_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!reset) req_ready = grant;
      end
      ISSUE:   eng_start = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Engine operands only change on accept, so they stay frozen for the whole job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_id  <= '0;
      eng_op  <= OP_DECRYPT;
      eng_msg <= '0;
    end else if (accept) begin
      job_id  <= grant_idx;
      eng_op  <= sel_op;
      eng_msg <= sel_msg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            rsp_data <= '0;
    else if (done_hit)    rsp_data <= eng_result;
    else if (timeout_hit) rsp_data <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (state == RESP && rsp_ready) begin
      ptr <= (job_id == IDW'(NREQ - 1)) ? '0 : job_id + 1'b1;
    end
  end

  assign rsp_id = job_id;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Scoreboard bench for rsa_job_arbiter: queue-based reference model, engine model and response monitor.
module tb_rsa_job_arbiter;

  localparam int W   = 256;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TMO = 64;

  typedef struct {
    int           id;
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  typedef struct {
    logic         op;
    logic [W-1:0] msg;
  } job_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_msg;
  logic           eng_start;
  logic           eng_op;
  logic [W-1:0]   eng_msg;
  logic           eng_done = 1'b0;
  logic [W-1:0]   eng_result = '0;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  int   last_grant_cyc = 0;
  int   start_cyc = 0;
  int   cur_lat = 0;
  int   lat_cfg = 20;
  int   eng_cnt = 0;
  bit   eng_hang = 1'b0;
  bit   job_live = 1'b0;
  job_t cur_job;

  rsp_t exp_q[$];
  job_t eng_q[$];
  int   grant_log[$];
  int   m_ptr = 0;
  bit   m_idle = 1'b1;
  logic [N-1:0] gnt_seen = '0;
  bit   rsp_cont = 1'b0;
  rsp_t popped;

  rsa_job_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_msg    (req_msg),
    .eng_start  (eng_start),
    .eng_op     (eng_op),
    .eng_msg    (eng_msg),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stand-in for the RSA core: any fixed, op-dependent function of the message will do.
  function automatic logic [W-1:0] model_result(input logic op, input logic [W-1:0] msg);
    if (op) return msg * 3 + 1;
    return msg ^ {8{32'hdeadbeef}};
  endfunction

  function automatic logic [W-1:0] rand_msg();
    logic [W-1:0] m;
    for (int i = 0; i < W / 32; i++) m[i*32 +: 32] = $urandom();
    return m;
  endfunction

  // Reference model: arbitration from the bench's own pointer and the driven request vector.
  always @(negedge clk) begin
    int           w;
    logic [N-1:0] exp_rdy;
    logic         err_exp;
    w = -1;
    exp_rdy = '0;
    err_exp = 1'b0;
    gnt_seen = req_ready;
    if (reset) begin
      m_ptr  = 0;
      m_idle = 1'b1;
      exp_q.delete();
      eng_q.delete();
    end else begin
      chk("busy", W'(busy), W'(!m_idle));
      if (m_idle) begin
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w >= 0) begin
`ifdef RSA_ARB_WDOG_EN
        err_exp = eng_hang;
`endif
        exp_rdy[w] = 1'b1;
        exp_q.push_back('{id: w,
                          data: err_exp ? '0 : model_result(req_op[w], req_msg[w*W +: W]),
                          err: err_exp});
        eng_q.push_back('{op: req_op[w], msg: req_msg[w*W +: W]});
        grant_log.push_back(w);
        last_grant_cyc = cyc;
        m_idle = 1'b0;
        m_ptr  = (w + 1) % N;
      end
      chk("req_ready", W'(req_ready), W'(exp_rdy));
      if (rsp_valid && rsp_ready) m_idle = 1'b1;
    end
  end

  // Engine model: counts down a latency after each start and checks the operands it was handed.
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (job_live && !reset) begin
        chk("eng_op_hold", W'(eng_op), W'(cur_job.op));
        chk("eng_msg_hold", eng_msg, cur_job.msg);
      end
      if (eng_cnt == 0) begin
        if (!eng_hang) begin
          eng_done   = 1'b1;
          eng_result = model_result(cur_job.op, cur_job.msg);
        end
        job_live = 1'b0;
      end
    end
    if (reset) begin
      job_live = 1'b0;
    end else if (eng_start) begin
      chk("start_after_grant", W'(cyc), W'(last_grant_cyc + 1));
      chk("start_expected", W'(eng_q.size() > 0), W'(1));
      if (eng_q.size() > 0) begin
        cur_job = eng_q.pop_front();
        chk("eng_op", W'(eng_op), W'(cur_job.op));
        chk("eng_msg", eng_msg, cur_job.msg);
      end
      cur_lat   = eng_hang ? TMO : (lat_cfg > 0 ? lat_cfg : int'($urandom_range(1, 12)));
      eng_cnt   = cur_lat;
      start_cyc = cyc;
      job_live  = 1'b1;
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks stability while held.
  always @(negedge clk) begin
    if (reset) begin
      rsp_cont = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (!rsp_cont) chk("rsp_latency", W'(cyc), W'(start_cyc + cur_lat + 1));
        chk("rsp_expected", W'(exp_q.size() > 0), W'(1));
        if (exp_q.size() > 0) begin
          chk("rsp_id", W'(rsp_id), W'(exp_q[0].id));
          chk("rsp_data", rsp_data, exp_q[0].data);
          chk("rsp_err", W'(rsp_err), W'(exp_q[0].err));
          if (rsp_ready) popped = exp_q.pop_front();
        end
      end
      rsp_cont = rsp_valid && !rsp_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~gnt_seen;
  endtask

  task automatic post(input int i, input logic op, input logic [W-1:0] msg);
    req_valid[i] = 1'b1;
    req_op[i] = op;
    req_msg[i*W +: W] = msg;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      if (!busy && req_valid == '0 && exp_q.size() == 0) ok = 1'b1;
    end
    chk("wait_idle", W'(ok), W'(1));
  endtask

  task automatic check_rst();
    chk("rst_req_ready", W'(req_ready), '0);
    chk("rst_eng_start", W'(eng_start), '0);
    chk("rst_eng_op", W'(eng_op), '0);
    chk("rst_eng_msg", eng_msg, '0);
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_rsp_id", W'(rsp_id), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_err", W'(rsp_err), '0);
    chk("rst_busy", W'(busy), '0);
  endtask

  task automatic pulse_reset();
    req_valid = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    req_valid = '0;
    req_op    = '0;
    req_msg   = '0;
    rsp_ready = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_rst();
    reset = 1'b0;
    tick();
    check_rst();

    // Single decrypt with a 20-cycle engine.
    rsp_ready = 1'b1;
    lat_cfg = 20;
    post(0, 1'b0, 256'h262d806a3e18f03ab37b2857e7e149);
    wait_idle(100);

    // Round robin with everybody requesting continuously.
    pulse_reset();
    base = grant_log.size();
    lat_cfg = 4;
    for (int i = 0; i < N; i++) post(i, 1'($urandom_range(0, 1)), rand_msg());
    for (int n = 0; n < 200 && grant_log.size() - base < 5; n++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) post(i, 1'($urandom_range(0, 1)), rand_msg());
    end
    req_valid = '0;
    chk("rr_count", W'(grant_log.size() - base >= 5), W'(1));
    if (grant_log.size() - base >= 5)
      for (int k = 0; k < 5; k++) chk("rr_order", W'(grant_log[base + k]), W'(exp_order[k]));
    wait_idle(100);

    // Op and message routing from requester 2.
    lat_cfg = 15;
    post(2, 1'b1, 256'h48656c6c6f20576f726c6421);
    wait_idle(100);

    // Response backpressure with a competing request pending.
    rsp_ready = 1'b0;
    lat_cfg = 6;
    post(1, 1'b0, rand_msg());
    for (int n = 0; n < 50 && !rsp_valid; n++) tick();
    chk("bp_rsp_seen", W'(rsp_valid), W'(1));
    post(3, 1'b1, rand_msg());
    repeat (10) begin
      tick();
      chk("bp_busy", W'(busy), W'(1));
      chk("bp_no_ready", W'(req_ready), '0);
      chk("bp_hold", W'(rsp_valid), W'(1));
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_next_grant", W'(req_ready), W'(4'b1000));
    wait_idle(100);

    // Reset in the middle of WAIT; the pointer must fall back to 0.
    lat_cfg = 5;
    post(1, 1'b1, rand_msg());
    wait_idle(60);
    lat_cfg = 20;
    post(2, 1'b0, rand_msg());
    for (int n = 0; n < 20 && !eng_start; n++) tick();
    chk("rst_start_seen", W'(eng_start), W'(1));
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check_rst();
    tick();
    reset = 1'b0;
    cnt = 0;
    repeat (25) begin
      tick();
      if (rsp_valid) cnt++;
    end
    chk("rst_no_rsp", W'(cnt), '0);
    base = grant_log.size();
    post(3, 1'b0, rand_msg());
    post(0, 1'b1, rand_msg());
    tick();
    chk("rst_next_grant", W'((grant_log.size() > base) ? grant_log[base] : -1), W'(0));
    wait_idle(100);

    // Randomised traffic with withdrawals and backpressure.
    lat_cfg = 0;
    for (int n = 0; n < 2500; n++) begin
      tick();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && $urandom_range(0, 39) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 9) < 3)
          post(i, 1'($urandom_range(0, 1)), rand_msg());
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(200);

    // Engine that never finishes.
    eng_hang = 1'b1;
    post(1, 1'b1, rand_msg());
`ifdef RSA_ARB_WDOG_EN
    wait_idle(120);
`else
    cnt = 0;
    repeat (150) begin
      tick();
      if (rsp_valid) cnt++;
    end
    chk("no_wdog_rsp", W'(cnt), '0);
    chk("hang_busy", W'(busy), W'(1));
    pulse_reset();
`endif
    eng_hang = 1'b0;
    tick();
    chk("scoreboard_drained", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
